// File: rtl/ft_cmd_responder.sv
// FT FIFO command/response engine: decodes 16-bit commands, replies with framed XOR-checksummed words.
// Optional macro FT_RESP_TIMEOUT_EN aborts a frame stalled by ui_din_full for TIMEOUT_CYCLES.
module ft_cmd_responder #(
    parameter logic [15:0] HDR_WORD       = 16'hA55A,
    parameter logic [15:0] TIMEOUT_CYCLES = 16'd4096
) (
    input  logic        clk_128M,
    input  logic        rst_128M,
    input  logic [15:0] ui_dout,
    input  logic [1:0]  ui_dout_be,
    input  logic        ui_dout_empty,
    output logic        ui_dout_get,
    output logic [15:0] ui_din,
    output logic [1:0]  ui_din_be,
    output logic        ui_din_valid,
    input  logic        ui_din_full,
    input  logic [31:0] total_packets,
    input  logic [31:0] mismatch_packets,
    input  logic        okay_led,
    input  logic        link_count_okay,
    output logic        reset_counters,
    output logic [15:0] err_count
);
    typedef enum logic [1:0] {IDLE, DECODE, SEND} state_t;

    state_t      state, state_nxt;
    logic [15:0] cmd;
    logic [31:0] total_snap, mis_snap;
    logic [1:0]  flags_snap;
    logic [7:0]  seq;
    logic [15:0] frame [8];
    logic [15:0] build [8];
    logic [15:0] chk;
    logic [2:0]  idx, last_idx, build_last;
    logic        accept, good_word, xfer, timeout, err_inc;

    assign ui_dout_get  = (state == IDLE) && !ui_dout_empty && !rst_128M;
    assign accept       = ui_dout_get;
    assign good_word    = accept && (ui_dout_be == 2'b11);
    assign ui_din_valid = (state == SEND) && !ui_din_full && !rst_128M;
    assign xfer         = ui_din_valid;
    assign ui_din       = frame[idx];
    assign ui_din_be    = 2'b11;
    assign err_inc      = (accept && !good_word) || timeout;

`ifdef FT_RESP_TIMEOUT_EN
    logic [15:0] stall;

    always_ff @(posedge clk_128M) begin
        if (rst_128M || state != SEND || xfer)
            stall <= '0;
        else if (ui_din_full)
            stall <= stall + 16'd1;
    end

    // The cycle on which the counter would reach the limit is the abort cycle.
    assign timeout = (state == SEND) && ui_din_full && (stall == TIMEOUT_CYCLES - 16'd1);
`else
    assign timeout = 1'b0 & (TIMEOUT_CYCLES != 16'd0);
`endif

    // Frame contents come from the snapshot, so the hi/lo halves stay coherent.
    always_comb begin
        for (int i = 0; i < 8; i++) build[i] = '0;
        build_last = 3'd3;
        case (cmd)
            16'h5201: begin
                build[0]   = HDR_WORD;
                build[1]   = {8'h52, seq};
                build[2]   = total_snap[31:16];
                build[3]   = total_snap[15:0];
                build[4]   = mis_snap[31:16];
                build[5]   = mis_snap[15:0];
                build[6]   = {14'b0, flags_snap};
                build_last = 3'd7;
            end
            16'h4300: begin
                build[0] = HDR_WORD;
                build[1] = {8'h43, seq};
                build[2] = 16'hC1EA;
            end
            default: begin
                build[0] = HDR_WORD;
                build[1] = {8'hEE, seq};
                build[2] = cmd;
            end
        endcase
        chk = '0;
        for (int i = 0; i < 8; i++) chk = chk ^ build[i];
        build[build_last] = chk;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (good_word) state_nxt = DECODE;
            DECODE:  state_nxt = SEND;
            SEND: begin
                if (xfer && idx == last_idx) state_nxt = IDLE;
                else if (timeout)            state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk_128M) begin
        if (state == DECODE)
            for (int i = 0; i < 8; i++) frame[i] <= build[i];
    end

    always_ff @(posedge clk_128M) begin
        if (rst_128M) begin
            state          <= IDLE;
            cmd            <= '0;
            total_snap     <= '0;
            mis_snap       <= '0;
            flags_snap     <= '0;
            seq            <= '0;
            idx            <= '0;
            last_idx       <= '0;
            reset_counters <= 1'b0;
            err_count      <= '0;
        end else begin
            state          <= state_nxt;
            reset_counters <= good_word && (ui_dout == 16'h4300);
            if (err_inc && err_count != 16'hFFFF)
                err_count <= err_count + 16'd1;
            if (good_word) begin
                cmd        <= ui_dout;
                total_snap <= total_packets;
                mis_snap   <= mismatch_packets;
                flags_snap <= {link_count_okay, okay_led};
            end
            if (state == DECODE) begin
                idx      <= '0;
                last_idx <= build_last;
            end
            if (xfer) begin
                idx <= idx + 3'd1;
                if (idx == last_idx) seq <= seq + 8'd1;
            end
        end
    end
endmodule

// File: tb/tb_ft_cmd_responder.sv
// Scoreboard bench for ft_cmd_responder: stimulus pushes expected words, a negedge monitor pops and compares.
module tb_ft_cmd_responder;
    logic        clk_128M = 1'b0;
    logic        rst_128M;
    logic [15:0] ui_dout;
    logic [1:0]  ui_dout_be;
    logic        ui_dout_empty;
    logic        ui_dout_get;
    logic [15:0] ui_din;
    logic [1:0]  ui_din_be;
    logic        ui_din_valid;
    logic        ui_din_full;
    logic [31:0] total_packets, mismatch_packets;
    logic        okay_led, link_count_okay;
    logic        reset_counters;
    logic [15:0] err_count;

    always #5 clk_128M = ~clk_128M;

    ft_cmd_responder #(.HDR_WORD(16'hA55A), .TIMEOUT_CYCLES(16'd16)) dut (
        .clk_128M(clk_128M), .rst_128M(rst_128M),
        .ui_dout(ui_dout), .ui_dout_be(ui_dout_be), .ui_dout_empty(ui_dout_empty),
        .ui_dout_get(ui_dout_get), .ui_din(ui_din), .ui_din_be(ui_din_be),
        .ui_din_valid(ui_din_valid), .ui_din_full(ui_din_full),
        .total_packets(total_packets), .mismatch_packets(mismatch_packets),
        .okay_led(okay_led), .link_count_okay(link_count_okay),
        .reset_counters(reset_counters), .err_count(err_count)
    );

    typedef struct { logic [15:0] w; int off; } exp_t;

    exp_t        exp_q[$];
    logic [17:0] ft_q[$];
    int          acc_hist[$];
    int          cyc = 0;
    int          accept_cyc = 0;
    int          checks = 0;
    int          errors = 0;
    int          pulses = 0;
    bit          toggle_en = 0;
    logic [7:0]  seq_m = 0;
    logic [15:0] err_m = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    always @(posedge clk_128M) cyc <= cyc + 1;

    // FT receive FIFO model: a word leaves when the DUT pulls it at the edge.
    always @(posedge clk_128M) begin
        if (!rst_128M && ui_dout_get && ft_q.size() > 0) begin
            void'(ft_q.pop_front());
            accept_cyc <= cyc;
            acc_hist.push_back(cyc);
        end
    end

    initial begin
        ui_dout_empty = 1'b1;
        ui_dout       = '0;
        ui_dout_be    = '0;
        forever begin
            @(posedge clk_128M);
            #2;
            if (ft_q.size() > 0) begin
                {ui_dout_be, ui_dout} = ft_q[0];
                ui_dout_empty = 1'b0;
            end else begin
                ui_dout_be    = '0;
                ui_dout       = '0;
                ui_dout_empty = 1'b1;
            end
        end
    end

    always begin
        @(posedge clk_128M);
        #1;
        if (toggle_en) ui_din_full = ~ui_din_full;
    end

    always @(negedge clk_128M) begin
        exp_t e;
        if (reset_counters) begin
            pulses++;
            chk("clear_pulse_cycle", cyc, accept_cyc + 1);
        end
        if (!rst_128M && ui_din_valid) begin
            chk("valid_while_full", ui_din_full, 1'b0);
            chk("din_be", ui_din_be, 2'b11);
            if (exp_q.size() == 0) begin
                chk("unexpected_word", ui_din, 16'hxxxx);
            end else begin
                e = exp_q.pop_front();
                chk("din_word", ui_din, e.w);
                if (e.off >= 0) chk("din_cycle", cyc, accept_cyc + 2 + e.off);
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) begin @(posedge clk_128M); #1; end
    endtask

    task automatic push_words(input logic [15:0] w[8], input int n, input bit timed);
        exp_t e;
        for (int i = 0; i < n; i++) begin
            e.w   = w[i];
            e.off = timed ? i : -1;
            exp_q.push_back(e);
        end
    endtask

    task automatic exp_status(input logic [7:0] s, input logic [31:0] t, input logic [31:0] m,
                              input logic [1:0] f, input bit timed);
        logic [15:0] w[8];
        w = '{16'hA55A, {8'h52, s}, t[31:16], t[15:0], m[31:16], m[15:0], {14'b0, f}, 16'h0};
        for (int i = 0; i < 7; i++) w[7] = w[7] ^ w[i];
        push_words(w, 8, timed);
    endtask

    task automatic drain(input int budget, input string name);
        int n = 0;
        while ((exp_q.size() > 0 || ft_q.size() > 0) && n < budget) begin
            tick(1);
            n++;
        end
        chk({name, "_drain_timeout"}, (n >= budget), 1'b0);
        exp_q.delete();
        tick(3);
    endtask

    initial begin
        rst_128M = 1'b1; ui_din_full = 1'b0;
        total_packets = '0; mismatch_packets = '0; okay_led = 1'b0; link_count_okay = 1'b0;
        tick(3);
        rst_128M = 1'b0;
        tick(1);
        chk("rst_din_valid", ui_din_valid, 1'b0);
        chk("rst_reset_counters", reset_counters, 1'b0);
        chk("rst_err_count", err_count, 16'h0);
        chk("rst_dout_get", ui_dout_get, 1'b0);

        // STATUS after reset, no backpressure
        total_packets = 32'h10; okay_led = 1'b1; link_count_okay = 1'b1;
        push_words('{16'hA55A, 16'h5200, 16'h0000, 16'h0010, 16'h0000, 16'h0000, 16'h0003, 16'hF749}, 8, 1);
        ft_q.push_back({2'b11, 16'h5201});
        drain(100, "status0");
        seq_m = 8'd1;

        // CLEAR with pulse
        pulses = 0;
        push_words('{16'hA55A, 16'h4301, 16'hC1EA, 16'h27B1, 16'h0, 16'h0, 16'h0, 16'h0}, 4, 1);
        ft_q.push_back({2'b11, 16'h4300});
        drain(100, "clear");
        chk("clear_pulse_count", pulses, 1);
        seq_m = 8'd2;

        // Unknown command, then a partial-byte word
        rst_128M = 1'b1; tick(2); rst_128M = 1'b0; tick(1);
        seq_m = 8'd0; err_m = 16'd0;
        push_words('{16'hA55A, 16'hEE00, 16'h1234, 16'h596E, 16'h0, 16'h0, 16'h0, 16'h0}, 4, 1);
        ft_q.push_back({2'b11, 16'h1234});
        drain(100, "unknown");
        seq_m = 8'd1;
        ft_q.push_back({2'b01, 16'h5201});
        drain(100, "bad_be");
        err_m = 16'd1;
        chk("bad_be_err_count", err_count, err_m);

        // Backpressure toggling, counters move mid-frame
        total_packets = 32'h0001_FFFF; mismatch_packets = 32'h0000_0002;
        okay_led = 1'b1; link_count_okay = 1'b0;
        push_words('{16'hA55A, 16'h5201, 16'h0001, 16'hFFFF, 16'h0000, 16'h0002, 16'h0001, 16'h08A6}, 8, 0);
        toggle_en = 1'b1;
        ft_q.push_back({2'b11, 16'h5201});
        tick(4);
        total_packets = 32'h0002_0000; mismatch_packets = 32'hFFFF_FFFF;
        okay_led = 1'b0; link_count_okay = 1'b1;
        drain(200, "toggle");
        toggle_en = 1'b0; ui_din_full = 1'b0;
        seq_m = 8'd2;

        // 256 back-to-back frames, seq wraps through 255 -> 0
        total_packets = 32'h1234_5678; mismatch_packets = 32'h0000_00AB;
        okay_led = 1'b1; link_count_okay = 1'b0;
        for (int i = 0; i < 256; i++) begin
            exp_status(seq_m, 32'h1234_5678, 32'h0000_00AB, 2'b01, 1);
            ft_q.push_back({2'b11, 16'h5201});
            seq_m = seq_m + 8'd1;
        end
        drain(5000, "wrap");
        chk("wrap_seq", seq_m, 8'd2);

        // Two queued commands: second accept exactly 10 cycles after the first
        acc_hist.delete();
        exp_status(seq_m, 32'h1234_5678, 32'h0000_00AB, 2'b01, 1);
        exp_status(seq_m + 8'd1, 32'h1234_5678, 32'h0000_00AB, 2'b01, 1);
        ft_q.push_back({2'b11, 16'h5201});
        ft_q.push_back({2'b11, 16'h5201});
        drain(100, "b2b");
        chk("b2b_accepts", acc_hist.size(), 2);
        if (acc_hist.size() == 2) chk("b2b_spacing", acc_hist[1] - acc_hist[0], 10);
        seq_m = seq_m + 8'd2;

        // Reset mid-frame
        begin
            int n = 0;
            exp_status(seq_m, 32'h1234_5678, 32'h0000_00AB, 2'b01, 1);
            ft_q.push_back({2'b11, 16'h5201});
            while (exp_q.size() > 5 && n < 100) begin tick(1); n++; end
            chk("midframe_progress", (n < 100), 1'b1);
        end
        rst_128M = 1'b1;
        exp_q.delete();
        tick(1);
        @(negedge clk_128M);
        chk("midframe_rst_valid", ui_din_valid, 1'b0);
        tick(1);
        rst_128M = 1'b0;
        tick(1);
        seq_m = 8'd0; err_m = 16'd0;
        push_words('{16'hA55A, 16'h4300, 16'hC1EA, 16'h27B0, 16'h0, 16'h0, 16'h0, 16'h0}, 4, 1);
        ft_q.push_back({2'b11, 16'h4300});
        drain(100, "post_rst_clear");
        seq_m = 8'd1;

        // Stall with ui_din_full held high
        ui_din_full = 1'b1;
`ifndef FT_RESP_TIMEOUT_EN
        exp_status(seq_m, 32'h1234_5678, 32'h0000_00AB, 2'b01, 0);
`endif
        ft_q.push_back({2'b11, 16'h5201});
        tick(25);
`ifdef FT_RESP_TIMEOUT_EN
        err_m = err_m + 16'd1;
        chk("stall_abort_err", err_count, err_m);
`else
        chk("stall_hold_words", exp_q.size(), 8);
        chk("stall_err", err_count, err_m);
        seq_m = seq_m + 8'd1;
`endif
        ui_din_full = 1'b0;
        drain(100, "stall");
        push_words('{16'hA55A, {8'h43, seq_m}, 16'hC1EA, 16'hA55A ^ {8'h43, seq_m} ^ 16'hC1EA,
                     16'h0, 16'h0, 16'h0, 16'h0}, 4, 1);
        ft_q.push_back({2'b11, 16'h4300});
        drain(100, "after_stall");
        chk("final_err_count", err_count, err_m);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/ft_cmd_responder.md
Name: ft_cmd_responder

Overview:
Command/response engine between the FT USB FIFO user interface and the telemetry checker counters, all in the clk_128M domain. Pulls 16-bit command words from the FT receive side (ui_dout), decodes them, and pushes framed, checksummed response words into the FT transmit side (ui_din). Replaces the raw ui_dout→ui_din loopback; counter inputs arrive already synchronized into clk_128M by upstream CDC.

Parameters:
HDR_WORD, 16'hA55A, first word of every response frame
TIMEOUT_CYCLES, 16'd4096, stall limit used only when FT_RESP_TIMEOUT_EN is defined

Ports:
clk_128M  in  1  system clock
rst_128M  in  1  synchronous active-high reset
ui_dout  in  16  FT receive word, first-word-fall-through
ui_dout_be  in  2  byte enables of ui_dout
ui_dout_empty  in  1  FT receive FIFO empty
ui_dout_get  out  1  consume ui_dout this cycle
ui_din  out  16  FT transmit word
ui_din_be  out  2  byte enables, always 2'b11
ui_din_valid  out  1  transmit word valid
ui_din_full  in  1  FT transmit FIFO full
total_packets  in  32  packet count from telemetry checker
mismatch_packets  in  32  mismatch count from telemetry checker
okay_led  in  1  checker okay flag
link_count_okay  in  1  checker link flag
reset_counters  out  1  one-cycle clear pulse to checker
err_count  out  16  saturating count of discarded/aborted events

Behaviour:
- Reset (sync, rst_128M=1 at posedge): state=IDLE; ui_dout_get=0, ui_din_valid=0, reset_counters=0, seq=0, err_count=0, snapshot regs=0. Reset mid-frame abandons the frame; ui_din_valid is 0 from the next cycle.
- States: IDLE, DECODE, SEND.
- IDLE: ui_dout_get = !ui_dout_empty (combinational). A word is accepted when ui_dout_get=1. If ui_dout_be!=2'b11, the word is discarded: err_count+1, stay IDLE. Otherwise latch cmd, snapshot total_packets, mismatch_packets and flags={okay_led? no: link_count_okay,okay_led} in that same cycle → DECODE.
- ui_dout_get=0 in DECODE and SEND; further commands wait in the FT FIFO.
- DECODE (exactly 1 cycle): build the frame, → SEND. Command encoding:
  - 16'h5201 STATUS: 8 words: HDR, {8'h52,seq}, total[31:16], total[15:0], mis[31:16], mis[15:0], {14'b0,link_count_okay,okay_led}, CHK.
  - 16'h4300 CLEAR: reset_counters=1 for exactly this DECODE cycle. 4 words: HDR, {8'h43,seq}, 16'hC1EA, CHK.
  - any other value: ERROR frame, 4 words: HDR, {8'hEE,seq}, cmd, CHK.
- CHK = XOR of all preceding words in the frame.
- SEND: ui_din/ui_din_be are muxed combinationally from the word index. ui_din_valid = !ui_din_full (combinational); it is never high while ui_din_full=1. A word transfers on a cycle with valid=1 and the index advances. After the last word transfers: seq+1 (8-bit, wraps 255→0), → IDLE.
- Latency: command accepted at cycle N; DECODE at N+1; first response word offered at N+2 if not full. With no backpressure, a STATUS frame occupies N+2..N+9, and the next command can be accepted at N+10.
- The snapshot guarantees the hi/lo halves are coherent even if the counters change during SEND.
- err_count saturates at 16'hFFFF and does not wrap.

Optional Feature:
FT_RESP_TIMEOUT_EN
- Defined: a stall counter increments on each SEND cycle with ui_din_full=1 and clears on each transfer. When it reaches TIMEOUT_CYCLES: abort the frame, err_count+1, seq unchanged, → IDLE. ui_din_valid is 0 from the next cycle.
- Undefined: SEND waits indefinitely; no counter logic is synthesized.

Test Plan:
- Reset, then STATUS (5201) with total=32'h10, mismatch=0, okay_led=1, link_count_okay=1, seq=0, din_full=0 → A55A,5200,0000,0010,0000,0000,0003,F749 on 8 consecutive cycles starting 2 cycles after accept; seq becomes 1.
- CLEAR (4300) at seq=1 → reset_counters high exactly 1 cycle, at accept+1; frame A55A,4301,C1EA,27B1.
- Unknown cmd 1234 at seq=0 → A55A,EE00,1234,596E; word with be=2'b01 → discarded, no frame, err_count=1.
- STATUS with din_full toggling every other cycle, counters changing mid-frame → same 8 words, snapshot values, no word duplicated or dropped, ui_din_valid never high while full; 256 frames → seq wraps to 00.
- Two commands queued back-to-back → second accepted only after the first frame's last word; reset asserted mid-frame → ui_din_valid=0 next cycle, then next command gets seq=00.
- With FT_RESP_TIMEOUT_EN and TIMEOUT_CYCLES=16: hold din_full=1 for 16 cycles in SEND → abort, err_count+1, IDLE; without the macro → stays in SEND and resumes when full drops.
